// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with 16x oversampling, an internal
// baud-tick generator and a small byte FIFO presented to the bus as
// zero-extended 16-bit words.
// Optional build macro UART_RX_MAJORITY_EN: each bit is decided by a 2-of-3
// vote of samples 6, 7 and 8 (decision at sample 8) instead of a single
// sample at 7.
module uart_rx_buffered #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_50m,
    input  logic                          rst,
    input  logic                          Rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [15:0]                   uart_rx_to_bus,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             rx_meta;
    logic             rx_s;
    state_t           state;
    logic [3:0]       samp_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             push;
    logic             decide;
    logic             bit_val;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    fill;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // Free-running divider producing one tick per oversample period.
    always_ff @(posedge clk_50m) begin
        if (rst || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + 1'b1;
    end
    assign tick = (div_cnt == DIV_LAST);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic v6;
    logic v7;

    // Capture samples 6 and 7; sample 8 is the live rx_s at decision time.
    always_ff @(posedge clk_50m) begin
        if (tick && samp_cnt == 4'd6) v6 <= rx_s;
        if (tick && samp_cnt == 4'd7) v7 <= rx_s;
    end
    assign decide  = tick && (samp_cnt == 4'd8);
    assign bit_val = maj3(v6, v7, rx_s);
`else
    assign decide  = tick && (samp_cnt == 4'd7);
    assign bit_val = rx_s;
`endif

    // Frame FSM: start detection, bit sampling, stop check and break hold-off.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state     <= IDLE;
            samp_cnt  <= '0;
            bit_idx   <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push <= 1'b0;
            if (tick) samp_cnt <= samp_cnt + 4'd1;
            if (err_clr) frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        samp_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (decide) begin
                        if (!bit_val) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (decide) begin
                        if (bit_val) begin
                            push  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            if (!err_clr) frame_err <= 1'b1;
                            state <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data shift register, LSB first; holds the byte until the push cycle.
    always_ff @(posedge clk_50m) begin
        if (state == DATA && decide) shreg <= {bit_val, shreg[7:1]};
    end

    assign full    = (fill == FULL_CNT);
    assign do_pop  = rd_en && (fill != '0);
    assign do_push = push && (!full || do_pop);

    // FIFO pointers, fill level and the sticky overrun flag.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (err_clr)                    overrun <= 1'b0;
            else if (push && full && !do_pop) overrun <= 1'b1;
        end
    end

    // FIFO storage; a full-and-popping push reuses the slot being freed.
    always_ff @(posedge clk_50m) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    assign ready          = (fill != '0);
    assign count          = fill;
    assign uart_rx_to_bus = ready ? {8'h00, mem[rd_ptr]} : 16'h0000;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Testbench for uart_rx_buffered: directed frame table, multi-cycle corner
// sequences and randomized frames against a queue-based reference model.
module tb_uart_rx_buffered;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 4;
    localparam int BIT      = 16 * (CLK_FREQ / (BAUD * 16));

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Rx = 1'b1;
    logic        rd_en = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] uart_rx_to_bus;
    logic        ready;
    logic [2:0]  count;
    logic        frame_err;
    logic        overrun;

    int total = 0;
    int bad = 0;

    logic [7:0] mq[$];
    bit         m_ovr;

    typedef struct {
        logic [7:0]  data;
        bit          stop;
        int          pops;
        bit          clr;
        int          e_cnt;
        logic [15:0] e_bus;
        bit          e_ferr;
        bit          e_ovr;
        int          p_cnt;
        logic [15:0] p_bus;
        bit          p_ferr;
        bit          p_ovr;
    } row_t;

    row_t tbl[8];

    uart_rx_buffered #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_50m(clk), .rst(rst), .Rx(Rx), .rd_en(rd_en), .err_clr(err_clr),
        .uart_rx_to_bus(uart_rx_to_bus), .ready(ready), .count(count),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input logic [15:0] b,
                               input bit ferr, input bit ovr);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".ready"}, 32'(ready), 32'(cnt != 0));
        chk({tag, ".bus"}, 32'(uart_rx_to_bus), 32'(b));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(ferr));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ovr));
    endtask

    task automatic drive_bit(input logic v);
        Rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    // Bad stop bit keeps the line low for two bit times, then one idle bit.
    task automatic send_frame(input logic [7:0] d, input bit stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        if (!stop) begin
            drive_bit(1'b0);
            drive_bit(1'b1);
        end
        Rx = 1'b1;
    endtask

    task automatic pulse_pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    function automatic logic [15:0] model_bus();
        return (mq.size() > 0) ? {8'h00, mq[0]} : 16'h0000;
    endfunction

    task automatic model_push(input logic [7:0] d);
        if (mq.size() < DEPTH) mq.push_back(d);
        else                   m_ovr = 1'b1;
    endtask

`ifdef UART_RX_MAJORITY_EN
    // Short inverted pulse around the mid-bit window of data bit gb.
    task automatic send_frame_glitch(input logic [7:0] d, input int gb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == gb) begin
                Rx = d[i];
                repeat (195) @(negedge clk);
                Rx = ~d[i];
                repeat (15) @(negedge clk);
                Rx = d[i];
                repeat (BIT - 210) @(negedge clk);
            end else begin
                drive_bit(d[i]);
            end
        end
        drive_bit(1'b1);
    endtask
`endif

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [7:0] d;
        logic [15:0] exp_pop [4];
        int np;

        tbl[0] = '{8'h55, 1'b1, 1, 1'b0, 1, 16'h0055, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{8'hA3, 1'b0, 0, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, 1'b1, 1, 1'b1, 1, 16'h003C, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{8'h01, 1'b1, 0, 1'b0, 1, 16'h0001, 1'b0, 1'b0, 1, 16'h0001, 1'b0, 1'b0};
        tbl[4] = '{8'h02, 1'b1, 0, 1'b0, 2, 16'h0001, 1'b0, 1'b0, 2, 16'h0001, 1'b0, 1'b0};
        tbl[5] = '{8'h03, 1'b1, 0, 1'b0, 3, 16'h0001, 1'b0, 1'b0, 3, 16'h0001, 1'b0, 1'b0};
        tbl[6] = '{8'h04, 1'b1, 0, 1'b0, 4, 16'h0001, 1'b0, 1'b0, 4, 16'h0001, 1'b0, 1'b0};
        tbl[7] = '{8'h05, 1'b1, 0, 1'b1, 4, 16'h0001, 1'b0, 1'b1, 4, 16'h0001, 1'b0, 1'b0};

        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("reset", 0, 16'h0000, 1'b0, 1'b0);

        // Start-bit glitch of three ticks must be rejected silently.
        Rx = 1'b0;
        repeat (81) @(negedge clk);
        Rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check_state("glitch", 0, 16'h0000, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            send_frame(tbl[r].data, tbl[r].stop);
            repeat (2) @(negedge clk);
            check_state($sformatf("row%0d", r), tbl[r].e_cnt, tbl[r].e_bus,
                        tbl[r].e_ferr, tbl[r].e_ovr);
            for (int p = 0; p < tbl[r].pops; p++) pulse_pop();
            if (tbl[r].clr) pulse_clr();
            check_state($sformatf("row%0d_post", r), tbl[r].p_cnt, tbl[r].p_bus,
                        tbl[r].p_ferr, tbl[r].p_ovr);
        end

        // FIFO full: pop in exactly the push cycle of 0x99.
        found = 1'b0;
        fork
            send_frame(8'h99, 1'b1);
            begin
                for (int c = 0; c < 11 * BIT && !found; c++) begin
                    @(negedge clk);
                    if (dut.push) begin
                        chk("push_cycle_head", 32'(uart_rx_to_bus), 32'h0001);
                        rd_en = 1'b1;
                        @(negedge clk);
                        rd_en = 1'b0;
                        found = 1'b1;
                    end
                end
            end
        join
        chk("push_cycle_seen", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        check_state("full_push_pop", 4, 16'h0002, 1'b0, 1'b0);
        exp_pop = '{16'h0002, 16'h0003, 16'h0004, 16'h0099};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), 32'(uart_rx_to_bus), 32'(exp_pop[i]));
            pulse_pop();
        end
        check_state("drained", 0, 16'h0000, 1'b0, 1'b0);

        // Reset in the middle of the data bits of 0x7E, then a clean 0x42.
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        Rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        check_state("rst_mid", 0, 16'h0000, 1'b0, 1'b0);
        send_frame(8'h42, 1'b1);
        repeat (2) @(negedge clk);
        check_state("after_rst", 1, 16'h0042, 1'b0, 1'b0);
        pulse_pop();

`ifdef UART_RX_MAJORITY_EN
        send_frame_glitch(8'hB4, 2);
        repeat (2) @(negedge clk);
        check_state("maj_glitch", 1, 16'h00B4, 1'b0, 1'b0);
        pulse_pop();
`endif

        // Randomized frames and pops against the queue model.
        mq.delete();
        m_ovr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            np = $urandom_range(0, 2);
            for (int j = 0; j < np; j++) begin
                chk($sformatf("rand%0d_pop%0d", k, j), 32'(uart_rx_to_bus), 32'(model_bus()));
                pulse_pop();
                if (mq.size() > 0) void'(mq.pop_front());
            end
            d = 8'($urandom);
            send_frame(d, 1'b1);
            model_push(d);
            repeat (2) @(negedge clk);
            check_state($sformatf("rand%0d", k), mq.size(), model_bus(), 1'b0, m_ovr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
- Standalone UART receive path: 8N1 frames on Rx, 16x oversampling, internal baud-tick generation, and a small byte FIFO.
- Presents received bytes to the processor bus as zero-extended 16-bit words, with a pop handshake.
- Complements the existing transmit path. Gives the bus side buffering and error status so no byte is lost between ready/clear cycles.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit. Fixed at 16; other values are unsupported.
- FIFO_DEPTH, 4, byte entries. Must be a power of 2, at least 2.

Ports:
- clk_50m  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- Rx  input  1  asynchronous serial line; idles high.
- rd_en  input  1  pop head byte; ignored when empty.
- err_clr  input  1  clears frame_err and overrun.
- uart_rx_to_bus  output  16  {8'h00, head byte} when non-empty; 16'h0000 when empty.
- ready  output  1  FIFO non-empty.
- count  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: byte arrived while FIFO full.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: ready=0, count=0, frame_err=0, overrun=0, uart_rx_to_bus=16'h0000.
  - Reset also sets FSM=IDLE, pointers=0, tick counter=0, synchronizer flops=1.
  - Reset asserted mid-frame abandons the partial byte; nothing is pushed.
- Input synchronization: Rx passes through a 2-flop synchronizer (rx_s) before any use.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer truncation (27 at defaults).
  - Counter 0..DIV-1 free-runs; emits a one-cycle tick at wrap.
  - One bit period = 16 ticks = 432 clocks at defaults.
- Sample counter: 4-bit, advances on ticks only.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE:
    - rx_s==0 clears the sample counter and moves to START.
  - START:
    - At sample 7 (mid-bit), rx_s==0 moves to DATA with bit index 0.
    - rx_s==1 at sample 7 is a glitch: return to IDLE, no push, no error.
  - DATA:
    - Sample at mid-bit each 16 ticks; shift in LSB first.
    - After bit 7, move to STOP.
  - STOP:
    - Mid-bit rx_s==1: push the byte, then IDLE.
    - Mid-bit rx_s==0: set frame_err, discard the byte, move to BREAK.
  - BREAK: stay until rx_s==1, then IDLE. This prevents a held-low line from generating spurious frames.
- FIFO:
  - Push occurs in the cycle after the stop-bit mid-sample. ready/count update the cycle after that.
  - Latency from stop-bit mid-sample to ready=1 is 2 clocks.
  - Push when full: byte dropped, overrun set, contents unchanged.
  - Push and rd_en in the same cycle when full: both take effect, count unchanged, overrun not set.
  - Push and rd_en in the same cycle when empty: push only.
  - rd_en when empty: no effect; pointers do not move.
  - Pointers wrap modulo FIFO_DEPTH.
  - uart_rx_to_bus always reflects the current head, combinationally from the registered read pointer.
- Error flags:
  - err_clr takes priority over setting in the same cycle.
  - Flags are cleared only by err_clr or rst.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each start, data and stop bit uses a 2-of-3 majority vote of rx_s at samples 6, 7 and 8. The decision is taken at sample 8; START glitch rejection uses the vote.
- Undefined: single sample at sample 7 as described above.
- FIFO, flag and latency behaviour are identical except decision timing moves 1 tick later.

Test Plan:
- 0x55 frame at 115200 -> ready=1 within 10 bit times + 2 clocks; count=1; uart_rx_to_bus=16'h0055; rd_en pulse -> ready=0, bus=16'h0000.
- Rx low for 3 ticks (81 clocks), then high -> no push, frame_err=0, FSM back in IDLE.
- Frame 0xA3 with stop bit 0, Rx held low 2 bit times -> count=0, frame_err=1; next valid 0x3C received correctly; err_clr -> frame_err=0.
- Frames 0x01..0x05 with no pops -> count=4, overrun=1, head=0x0001; four pops yield 01,02,03,04.
- FIFO full, rd_en asserted in the push cycle of 0x99 -> count stays 4, overrun=0, 0x99 is last out.
- rst asserted mid-DATA of 0x7E, released, then 0x42 sent -> only 0x0042 appears, count=1. Repeat with UART_RX_MAJORITY_EN and a 1-sample glitch inside a data bit -> byte still correct.
